// File: rtl/dtree_oblique.sv
// Oblique decision-tree classifier: collects FEATURES samples, then walks DEPTH levels of bias + sum(coeff*x) sign tests.
// Optional build macro DTREE_SATURATE_EN: clamp the accumulator instead of wrapping it.
module dtree_oblique #(
  parameter int FEATURES    = 3,
  parameter int DEPTH       = 3,
  parameter int IN_WIDTH    = 10,
  parameter int COEFF_WIDTH = 4,
  localparam int N          = (1 << DEPTH) - 1,
  localparam int AW         = (N * FEATURES > 1) ? $clog2(N * FEATURES) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] sample,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DEPTH-1:0]    out_class,
  output logic                out_ovf,
  output logic                busy,
  input  logic                cfg_we,
  input  logic                cfg_sel,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [IN_WIDTH-1:0] cfg_data
);

  localparam int FW   = (FEATURES > 1) ? $clog2(FEATURES) : 1;
  localparam int LW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW   = (N > 1) ? $clog2(N) : 1;
  localparam int NW   = DEPTH + 1;
  localparam int ACCW = IN_WIDTH + 1;
  localparam logic [FW-1:0] F_LAST   = FW'(FEATURES - 1);
  localparam logic [LW-1:0] L_LAST   = LW'(DEPTH - 1);
  localparam logic [AW:0]   COEF_CNT = (AW + 1)'(N * FEATURES);
  localparam logic [AW:0]   BIAS_CNT = (AW + 1)'(N);

  typedef enum logic [2:0] {COLLECT, LOAD, MAC, DECIDE, DONE} state_t;

  state_t                            state;
  logic        [FW-1:0]              f;
  logic        [LW-1:0]              level;
  logic        [NW-1:0]              node;
  logic        [DEPTH-1:0]           path;
  logic signed [ACCW-1:0]            acc;

  logic signed [COEFF_WIDTH-1:0]     coeff_mem [N*FEATURES];
  logic signed [IN_WIDTH-1:0]        bias_mem  [N];
  logic signed [IN_WIDTH-1:0]        buffer    [FEATURES];

  logic        [AW-1:0]              cidx;
  logic        [BW-1:0]              bidx;
  logic signed [COEFF_WIDTH-1:0]     coef_cur;
  logic signed [IN_WIDTH-1:0]        x_cur;
  logic signed [IN_WIDTH+COEFF_WIDTH-1:0] prod;
  logic signed [ACCW-1:0]            scaled;
  logic        [ACCW:0]              sum_ext;
  logic                              add_ovf;
  logic signed [ACCW-1:0]            acc_next;

  assign busy     = (state != COLLECT);
  assign in_ready = (state == COLLECT) && !reset;

  // Table writes are only honoured while idle so a classification sees a consistent tree.
  always_ff @(posedge clk) begin
    if (cfg_we && !busy) begin
      if (!cfg_sel && ({1'b0, cfg_addr} < COEF_CNT))
        coeff_mem[cfg_addr] <= cfg_data[COEFF_WIDTH-1:0];
      if (cfg_sel && ({1'b0, cfg_addr} < BIAS_CNT))
        bias_mem[BW'(cfg_addr)] <= cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready)
      buffer[f] <= sample;
  end

  assign cidx     = AW'(node * FEATURES + f);
  assign bidx     = BW'(node);
  assign coef_cur = coeff_mem[cidx];
  assign x_cur    = buffer[f];
  assign prod     = coef_cur * x_cur;
  assign scaled   = ACCW'(prod >>> (COEFF_WIDTH - 1));
  assign sum_ext  = {acc[ACCW-1], acc} + {scaled[ACCW-1], scaled};
  assign add_ovf  = sum_ext[ACCW] ^ sum_ext[ACCW-1];

`ifdef DTREE_SATURATE_EN
  always_comb begin
    acc_next = sum_ext[ACCW-1:0];
    if (add_ovf)
      acc_next = sum_ext[ACCW] ? {1'b1, {IN_WIDTH{1'b0}}} : {1'b0, {IN_WIDTH{1'b1}}};
  end
`else
  assign acc_next = sum_ext[ACCW-1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= COLLECT;
      f         <= '0;
      level     <= '0;
      node      <= '0;
      path      <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_class <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (in_valid) begin
            if (f == F_LAST) begin
              f     <= '0;
              state <= LOAD;
            end else begin
              f <= f + FW'(1);
            end
          end
        end
        LOAD: begin
          acc   <= {bias_mem[bidx][IN_WIDTH-1], bias_mem[bidx]};
          f     <= '0;
          state <= MAC;
        end
        MAC: begin
          acc <= acc_next;
          if (add_ovf)
            out_ovf <= 1'b1;
          if (f == F_LAST) begin
            f     <= '0;
            state <= DECIDE;
          end else begin
            f <= f + FW'(1);
          end
        end
        DECIDE: begin
          // Negative result selects the right child: node*2+2.
          node <= {node[NW-2:0], 1'b1} + NW'(acc[ACCW-1]);
          path <= DEPTH'({path, acc[ACCW-1]});
          if (level == L_LAST) begin
            out_class <= DEPTH'({path, acc[ACCW-1]});
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            level <= level + LW'(1);
            state <= LOAD;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_class <= '0;
            out_ovf   <= 1'b0;
            node      <= '0;
            level     <= '0;
            path      <= '0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_oblique.sv
// Bench for dtree_oblique: directed tree cases plus random tables/vectors against an arithmetic reference model.
module tb_dtree_oblique;
  localparam int FEATURES    = 3;
  localparam int DEPTH       = 3;
  localparam int IN_WIDTH    = 10;
  localparam int COEFF_WIDTH = 4;
  localparam int N           = (1 << DEPTH) - 1;
  localparam int AW          = $clog2(N * FEATURES);
  localparam int LATENCY     = DEPTH * (FEATURES + 2);

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [IN_WIDTH-1:0] sample = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [DEPTH-1:0]    out_class;
  logic                out_ovf;
  logic                busy;
  logic                cfg_we = 1'b0;
  logic                cfg_sel = 1'b0;
  logic [AW-1:0]       cfg_addr = '0;
  logic [IN_WIDTH-1:0] cfg_data = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int mc[N*FEATURES];
  int mb[N];

  dtree_oblique #(
    .FEATURES(FEATURES), .DEPTH(DEPTH), .IN_WIDTH(IN_WIDTH), .COEFF_WIDTH(COEFF_WIDTH)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .sample(sample),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_ovf(out_ovf),
    .busy(busy), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: evaluate the tree with plain integer arithmetic.
  function automatic void model(input int xv[FEATURES], output int cls, output int ovf);
    int node, acc, p;
    int hi = (1 << IN_WIDTH) - 1;
    int lo = -(1 << IN_WIDTH);
    node = 0; cls = 0; ovf = 0;
    for (int l = 0; l < DEPTH; l++) begin
      acc = mb[node];
      for (int k = 0; k < FEATURES; k++) begin
        p   = mc[node*FEATURES+k] * xv[k];
        acc = acc + (p >>> (COEFF_WIDTH - 1));
        if (acc > hi || acc < lo) begin
          ovf = 1;
`ifdef DTREE_SATURATE_EN
          acc = (acc > hi) ? hi : lo;
`else
          acc = (acc > hi) ? acc - 2 * (hi + 1) : acc + 2 * (hi + 1);
`endif
        end
      end
      cls  = cls * 2 + int'(acc < 0);
      node = 2 * node + 1 + int'(acc < 0);
    end
  endfunction

  task automatic cfg_write(input bit sel, input int addr, input int data);
    int v;
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr[AW-1:0]; cfg_data = data[IN_WIDTH-1:0];
    @(negedge clk);
    cfg_we = 1'b0;
    if (!sel) begin
      v = data & ((1 << COEFF_WIDTH) - 1);
      if (v >= (1 << (COEFF_WIDTH - 1))) v -= (1 << COEFF_WIDTH);
      mc[addr] = v;
    end else begin
      v = data & ((1 << IN_WIDTH) - 1);
      if (v >= (1 << (IN_WIDTH - 1))) v -= (1 << IN_WIDTH);
      mb[addr] = v;
    end
  endtask

  task automatic send_vec(input string tag, input int xv[FEATURES]);
    int w;
    for (int k = 0; k < FEATURES; k++) begin
      in_valid = 1'b1;
      sample   = xv[k][IN_WIDTH-1:0];
      w = 0;
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      chk({tag, ".in_ready"}, in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, ".out_valid"}, out_valid, 1);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".valid_drop"}, out_valid, 0);
    chk({tag, ".ready_back"}, in_ready, 1);
  endtask

  task automatic run_vec(input string tag, input int x0, input int x1, input int x2,
                         input int exp_cls, input int exp_ovf, input int hold);
    int xv[FEATURES];
    int cyc;
    xv[0] = x0; xv[1] = x1; xv[2] = x2;
    send_vec(tag, xv);
    wait_result(tag, cyc);
    chk({tag, ".latency"}, cyc, LATENCY);
    chk({tag, ".class"}, out_class, exp_cls);
    chk({tag, ".ovf"}, out_ovf, exp_ovf);
    for (int h = 0; h < hold; h++) @(negedge clk);
    consume(tag);
  endtask

  initial begin
    int cls, ov, cyc;
    int xv[FEATURES];

    // Reset state
    @(negedge clk);
    chk("rst.in_ready_low", in_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_class", out_class, 0);
    chk("rst.out_ovf", out_ovf, 0);
    chk("rst.busy", busy, 0);
    chk("rst.in_ready", in_ready, 1);
    @(negedge clk);

    // All coefficients 0, biases +1: every node goes left
    for (int a = 0; a < N * FEATURES; a++) cfg_write(1'b0, a, 0);
    for (int a = 0; a < N; a++) cfg_write(1'b1, a, 1);
    run_vec("t1", 5, 6, 7, 0, 0, 0);

    // Biases -1: every node goes right
    for (int a = 0; a < N; a++) cfg_write(1'b1, a, 'h3FF);
    run_vec("t2", 5, 6, 7, 7, 0, 0);

    // Root coefficient 0.875 on x0=-8 gives -7: right, then left, left
    for (int a = 0; a < N; a++) cfg_write(1'b1, a, 1);
    cfg_write(1'b1, 0, 0);
    cfg_write(1'b0, 0, 'h7);
    run_vec("t3", -8, 0, 0, 4, 0, 0);

    // Hold in DONE with a write attempt that must be ignored
    xv[0] = -8; xv[1] = 0; xv[2] = 0;
    send_vec("hold", xv);
    wait_result("hold", cyc);
    for (int h = 0; h < 10; h++) begin
      cfg_we = (h == 2); cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
      chk("hold.out_valid", out_valid, 1);
      chk("hold.out_class", out_class, 4);
      chk("hold.in_ready", in_ready, 0);
      chk("hold.busy", busy, 1);
      @(negedge clk);
    end
    cfg_we = 1'b0;
    consume("hold");

    // Reset during MAC aborts; tables survive (and the DONE-time write had no effect)
    send_vec("abort", xv);
    @(negedge clk);
    @(negedge clk);
    chk("abort.busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort.in_ready", in_ready, 1);
    chk("abort.out_valid", out_valid, 0);
    @(negedge clk);
    run_vec("replay", -8, 0, 0, 4, 0, 0);

    // Accumulator overflow on the root
    cfg_write(1'b1, 0, 511);
    cfg_write(1'b0, 1, 'h7);
    cfg_write(1'b0, 2, 'h7);
`ifdef DTREE_SATURATE_EN
    run_vec("t4", 511, 511, 511, 0, 1, 0);
`else
    run_vec("t4", 511, 511, 511, 4, 1, 0);
`endif

    // Random tables and vectors against the model
    for (int r = 0; r < 36; r++) begin
      if (r % 12 == 0) begin
        for (int a = 0; a < N * FEATURES; a++) cfg_write(1'b0, a, int'($urandom_range(0, 15)));
        for (int a = 0; a < N; a++) cfg_write(1'b1, a, int'($urandom_range(0, 1023)));
      end
      for (int k = 0; k < FEATURES; k++) xv[k] = int'($urandom_range(0, 1023)) - 512;
      model(xv, cls, ov);
      run_vec("rnd", xv[0], xv[1], xv[2], cls, ov, int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
